// File: rtl/alu_arbiter_pkg.sv
// Shared constants, opcodes and FSM encoding for the ALU arbiter.
// Imported by the interface, the arbiter and its round-robin helper.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OPW   = 4;

  localparam logic [OPW-1:0] OP_INC  = 4'b0000;
  localparam logic [OPW-1:0] OP_DEC  = 4'b0001;
  localparam logic [OPW-1:0] OP_SUB  = 4'b0010;
  localparam logic [OPW-1:0] OP_ADD  = 4'b0011;
  localparam logic [OPW-1:0] OP_LAST = OP_ADD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response handshake bundle for alu_arbiter.
// master = requesters/consumer side, slave = the arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int W = WIDTH,
  parameter int O = OPW
);

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [O-1:0] req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [O-1:0] req1_op;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_y;
  logic         rsp_c;
  logic         rsp_v;
  logic         rsp_z;
  logic         rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_y,
    input  rsp_c, rsp_v, rsp_z, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_y,
    output rsp_c, rsp_v, rsp_z, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant with the last-grant register.
// last resets to 1 so requester 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       upd,
  output logic       gnt_vld,
  output logic       gnt
);

  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= gnt;
    end
  end

  always_comb begin
    gnt_vld = |valid;
    gnt     = (valid == 2'b11) ? ~last : valid[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Grant, latch operands, one EXEC cycle, then hold a tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_z,
  output logic             busy,
  output logic [15:0]      done_cnt
);

  state_t state, nxt;
  logic   gnt, gnt_vld;
  logic   acc, rsp_hs, idle, id_q;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({bus.req1_valid, bus.req0_valid}),
    .upd     (acc),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  assign idle = (state == IDLE);
  assign bus.req0_ready = idle && gnt_vld && !gnt && bus.req0_valid;
  assign bus.req1_ready = idle && gnt_vld && gnt && bus.req1_valid;
  assign acc = bus.req0_ready || bus.req1_ready;
  assign bus.rsp_valid = (state == RESP);
  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
  assign busy = !idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = EXEC;
      EXEC: nxt = RESP;
      RESP: if (rsp_hs) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // alu_* double as the operand registers and hold between operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      id_q   <= 1'b0;
    end else if (acc) begin
      alu_a  <= gnt ? bus.req1_a  : bus.req0_a;
      alu_b  <= gnt ? bus.req1_b  : bus.req0_b;
      alu_op <= gnt ? bus.req1_op : bus.req0_op;
      id_q   <= gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_id  <= 1'b0;
      bus.rsp_y   <= '0;
      bus.rsp_c   <= 1'b0;
      bus.rsp_v   <= 1'b0;
      bus.rsp_z   <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else if (state == EXEC) begin
      bus.rsp_id <= id_q;
      if (op_legal(alu_op)) begin
        bus.rsp_y   <= alu_y;
        bus.rsp_c   <= alu_c;
        bus.rsp_v   <= alu_v;
        bus.rsp_z   <= alu_z;
        bus.rsp_err <= 1'b0;
      end else begin
        bus.rsp_y   <= '0;
        bus.rsp_c   <= 1'b0;
        bus.rsp_v   <= 1'b0;
        bus.rsp_z   <= 1'b0;
        bus.rsp_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 16'd0;
    end else if (rsp_hs) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 16-bit `alu` (ops A+1, A-1, A-B, A+B; flags C, V, Z) between two requester ports.
- Each requester issues a valid/ready handshake. The block grants one requester by round-robin, latches its operands and drives them to the ALU.
- It captures Y/C/V/Z into registers and returns a tagged response on a single valid/ready response port.
- Sits between the instruction-issue logic and the `alu` instance; the ALU itself stays external.

Parameters:
- WIDTH, 16, operand/result width (matches `alu`).
- OPW, 4, opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_op  in  OPW  opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_y  out  WIDTH  ALU result.
- rsp_c, rsp_v, rsp_z  out  1 each  ALU flags.
- rsp_err  out  1  illegal opcode.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_op  out  OPW  opcode to the ALU.
- alu_y  in  WIDTH  ALU result.
- alu_c, alu_v, alu_z  in  1 each  ALU flags.
- busy  out  1  state != IDLE.
- done_cnt  out  16  completed responses, wraps.

Behaviour:
- Reset (async, rst_n=0) clears:
  - state to IDLE;
  - all rsp_* to 0;
  - alu_a/alu_b/alu_op to 0;
  - last_grant to 1, so req0 wins first;
  - done_cnt to 0.
  Any transaction in flight is dropped and no response is produced.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational: if only one reqN_valid, grant N; if both, grant the one != last_grant.
  - reqN_ready = (state==IDLE) && grant==N && reqN_valid. The ready path depends only on valid, so there is no loop.
  - On handshake: latch a/b/op/id into operand registers, set last_grant=id, go to EXEC.
- EXEC (one cycle):
  - alu_a/alu_b/alu_op are driven from the operand registers. They are registered, so the ALU sees stable values for the whole cycle.
  - At the end of the cycle, capture into rsp_*:
    - legal op (0000–0011): rsp_y/c/v/z from alu_*, rsp_err=0;
    - illegal op (>0011): rsp_y=0, flags=0, rsp_err=1.
  - Go to RESP.
- RESP:
  - rsp_valid=1; all rsp_* held stable until rsp_ready=1.
  - On handshake: done_cnt+1 (wraps FFFF→0000), go to IDLE.
  - Both req*_ready are 0 in this state.
- Latency: request accepted at edge t → rsp_valid high from cycle t+2. Minimum 3 cycles per operation (no overlap).
- alu_* outputs hold their last value outside EXEC.
- A requester that deasserts valid before being granted is not served; no request is queued.
- rsp_valid and rsp_ready in the same cycle as a new req_valid: the response completes this cycle; the new request is accepted in the next IDLE cycle.

Decomposition:
- Package alu_pkg holds:
  - WIDTH=16;
  - opcodes OP_INC=4'b0000, OP_DEC=4'b0001, OP_SUB=4'b0010, OP_ADD=4'b0011;
  - OP_LAST=OP_ADD, used for the legality check;
  - state encoding IDLE/EXEC/RESP.
- One sub-module, rr_arb2: 2-way round-robin grant from valid[1:0] and last_grant. It is combinational plus the last_grant register.
- The ALU stays external.

Test Plan:
- Reset, then req0 A=0005 B=0002 op=0011, rsp_ready=1 → req0_ready at t, rsp_valid at t+2, rsp_y=0007, rsp_id=0, rsp_err=0, done_cnt=1.
- req1 A=0005 B=0002 op=0010 → rsp_y=0003, rsp_id=1. Then req0 A=0001 op=0001 → rsp_y=0000, rsp_z=1.
- After reset, both valid continuously with different ops → grants alternate 0,1,0,1; rsp_id sequence matches; no requester is served twice in a row.
- rsp_ready held low 5 cycles in RESP → rsp_* stable, busy=1, both req ready=0. Raise rsp_ready → IDLE next cycle, done_cnt increments once.
- req0 op=0111 A=1234 → rsp_err=1, rsp_y=0000, flags 0, done_cnt increments.
- rst_n low mid-EXEC → all outputs zero immediately (async), no response. Next request after release is served by req0 first.
